// File: rtl/vdma_frame_buf_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vdma_pkg
// Shared types and constants for the VDMA triple-buffer frame scheduler.
//   w_state_e     : write-side FSM encoding (W_IDLE / W_ACTIVE)
//   buf_idx_t     : frame-buffer index (0..NUM_FRAME_BUF-1)
//   NUM_FRAME_BUF : number of DDR frame buffers being rotated
//   free_idx()    : lowest buffer owned by neither the reader nor the newest
//                   completed frame
// -----------------------------------------------------------------------------
package vdma_pkg;

    localparam int NUM_FRAME_BUF = 3;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } w_state_e;

    typedef logic [1:0] buf_idx_t;

    // With three buffers and at most two of them claimed (reader + latest),
    // some index always survives the search.
    function automatic buf_idx_t free_idx(
        input buf_idx_t rd_idx,
        input buf_idx_t latest_idx,
        input logic     latest_valid
    );
        buf_idx_t res;
        res = '0;
        for (int i = NUM_FRAME_BUF - 1; i >= 0; i--) begin
            if ((buf_idx_t'(i) != rd_idx) &&
                (!latest_valid || (buf_idx_t'(i) != latest_idx))) begin
                res = buf_idx_t'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vdma_frame_buf_scheduler_if.sv
// -----------------------------------------------------------------------------
// vdma_frame_buf_scheduler_if
// Bundle between the scheduler and its environment (frame writer, video
// reader, configuration/status).
//
// Signalling: there is no valid/ready pairing here. Every event input
// (wr_frame_start, wr_frame_done, wr_frame_abort) and every event output
// (rd_repeat, wr_drop) is a single-cycle pulse, sampled on pclk rising edges
// and already synchronous to pclk. rd_vsync is a level; only its rising edge
// carries meaning. Address/index outputs are levels that are stable between
// the events that change them.
//
//   master : drives enable, base_addr_cfg, writer events and rd_vsync
//   slave  : the scheduler; drives addresses, indices, pulses, counters and
//            the write-FSM state (wr_state) for observation
// -----------------------------------------------------------------------------
interface vdma_frame_buf_scheduler_if
    import vdma_pkg::*;
#(
    parameter int ADDR_BITS = 25
);
    logic                 enable;
    logic [ADDR_BITS-1:0] base_addr_cfg;
    logic                 wr_frame_start;
    logic                 wr_frame_done;
    logic                 wr_frame_abort;
    logic [ADDR_BITS-1:0] wr_baseaddr;
    logic                 rd_vsync;
    logic [ADDR_BITS-1:0] rd_baseaddr;
    buf_idx_t             wr_idx;
    buf_idx_t             rd_idx;
    buf_idx_t             latest_idx;
    logic                 latest_valid;
    logic                 rd_repeat;
    logic                 wr_drop;
    logic [15:0]          repeat_cnt;
    logic [15:0]          drop_cnt;
    w_state_e             wr_state;

    modport master (
        output enable, base_addr_cfg, wr_frame_start, wr_frame_done,
               wr_frame_abort, rd_vsync,
        input  wr_baseaddr, rd_baseaddr, wr_idx, rd_idx, latest_idx,
               latest_valid, rd_repeat, wr_drop, repeat_cnt, drop_cnt,
               wr_state
    );

    modport slave (
        input  enable, base_addr_cfg, wr_frame_start, wr_frame_done,
               wr_frame_abort, rd_vsync,
        output wr_baseaddr, rd_baseaddr, wr_idx, rd_idx, latest_idx,
               latest_valid, rd_repeat, wr_drop, repeat_cnt, drop_cnt,
               wr_state
    );

endinterface

// File: rtl/vdma_frame_buf_scheduler_sat_counter.sv
// -----------------------------------------------------------------------------
// vdma_sat_counter
// W-bit event counter that sticks at all-ones instead of wrapping.
//   pclk   : clock
//   prst_n : asynchronous active-low reset
//   i_clr  : synchronous clear (dominates i_inc)
//   i_inc  : count one event this cycle
//   o_cnt  : current count
// -----------------------------------------------------------------------------
module vdma_sat_counter #(
    parameter int W = 16
) (
    input  logic         pclk,
    input  logic         prst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vdma_frame_buf_scheduler.sv
// -----------------------------------------------------------------------------
// vdma_frame_buf_scheduler
// Triple-buffer scheduler for the VDMA DDR frame store. Hands the writer a
// buffer that is neither being displayed nor the newest completed frame, and
// moves the reader onto the newest completed frame at each vsync.
//   pclk   : clock
//   prst_n : asynchronous active-low reset
//   bus    : vdma_frame_buf_scheduler_if.slave (enable/config, writer events,
//            rd_vsync in; base addresses, indices, pulses, counters out)
// Parameters:
//   ADDR_BITS    : DDR word-address width
//   FRAME_STRIDE : offset between consecutive buffers
// -----------------------------------------------------------------------------
module vdma_frame_buf_scheduler
    import vdma_pkg::*;
#(
    parameter int                   ADDR_BITS    = 25,
    parameter logic [ADDR_BITS-1:0] FRAME_STRIDE = ADDR_BITS'(32'h0008_0000)
) (
    input  logic                        pclk,
    input  logic                        prst_n,
    vdma_frame_buf_scheduler_if.slave   bus
);

    // Offset of buffer n from base_addr_cfg, truncated to ADDR_BITS.
    function automatic logic [ADDR_BITS-1:0] idx_off(input buf_idx_t idx);
        logic [ADDR_BITS-1:0] off;
        case (idx)
            2'd1:    off = FRAME_STRIDE;
            2'd2:    off = FRAME_STRIDE + FRAME_STRIDE;
            default: off = '0;
        endcase
        return off;
    endfunction

    w_state_e             r_state;
    w_state_e             w_state_next;
    logic                 w_take_start;
    logic                 w_take_done;
    logic                 w_drop_evt;

    buf_idx_t             r_wr_idx;
    buf_idx_t             r_rd_idx;
    buf_idx_t             r_latest_idx;
    logic                 r_latest_valid;
    buf_idx_t             w_free_idx;
    buf_idx_t             w_rd_idx_next;

    logic                 r_vsync_d1;
    logic                 r_vsync_d2;
    logic                 w_vsync_rise;
    logic                 w_rd_adopt;
    logic                 w_repeat_evt;

    logic                 r_rd_repeat;
    logic                 r_wr_drop;
    // Offsets rather than full addresses are registered so the reset value
    // (offset 0) yields base_addr_cfg without loading a non-constant reset.
    logic [ADDR_BITS-1:0] r_rd_off;
    logic [ADDR_BITS-1:0] r_wr_off;

    logic [15:0]          w_repeat_cnt;
    logic [15:0]          w_drop_cnt;

    // ---------------------------------------------------------------- write FSM
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= W_IDLE;
        end else if (!bus.enable) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // abort > done > start. A start alongside done is lost and counted.
    always_comb begin
        w_state_next = r_state;
        w_take_start = 1'b0;
        w_take_done  = 1'b0;
        w_drop_evt   = 1'b0;
        case (r_state)
            W_IDLE: begin
                if (bus.wr_frame_start) begin
                    w_state_next = W_ACTIVE;
                    w_take_start = 1'b1;
                end
            end
            W_ACTIVE: begin
                if (bus.wr_frame_abort) begin
                    w_state_next = W_IDLE;
                end else if (bus.wr_frame_done) begin
                    w_state_next = W_IDLE;
                    w_take_done  = 1'b1;
                    w_drop_evt   = bus.wr_frame_start;
                end else if (bus.wr_frame_start) begin
                    w_drop_evt   = 1'b1;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- read side
    assign w_vsync_rise  = r_vsync_d1 & ~r_vsync_d2;
    // Uses the pre-update latest: a done in the same cycle waits for next vsync.
    assign w_rd_adopt    = w_vsync_rise && r_latest_valid && (r_latest_idx != r_rd_idx);
    assign w_repeat_evt  = w_vsync_rise && !w_rd_adopt;
    assign w_rd_idx_next = w_rd_adopt ? r_latest_idx : r_rd_idx;
    assign w_free_idx    = free_idx(r_rd_idx, r_latest_idx, r_latest_valid);

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_vsync_d1 <= 1'b0;
            r_vsync_d2 <= 1'b0;
        end else begin
            r_vsync_d1 <= bus.rd_vsync;
            r_vsync_d2 <= r_vsync_d1;
        end
    end

    // ---------------------------------------------------------------- ownership
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_rd_idx       <= 2'd0;
            r_latest_idx   <= 2'd0;
            r_wr_idx       <= 2'd1;
            r_latest_valid <= 1'b0;
            r_rd_off       <= '0;
            r_wr_off       <= '0;
            r_rd_repeat    <= 1'b0;
            r_wr_drop      <= 1'b0;
        end else if (!bus.enable) begin
            r_rd_idx       <= 2'd0;
            r_latest_idx   <= 2'd0;
            r_wr_idx       <= 2'd1;
            r_latest_valid <= 1'b0;
            r_rd_off       <= '0;
            r_wr_off       <= '0;
            r_rd_repeat    <= 1'b0;
            r_wr_drop      <= 1'b0;
        end else begin
            r_rd_idx    <= w_rd_idx_next;
            r_rd_off    <= idx_off(w_rd_idx_next);
            r_rd_repeat <= w_repeat_evt;
            r_wr_drop   <= w_drop_evt;
            if (w_take_start) begin
                r_wr_idx <= w_free_idx;
                r_wr_off <= idx_off(w_free_idx);
            end
            if (w_take_done) begin
                r_latest_idx   <= r_wr_idx;
                r_latest_valid <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- counters
    vdma_sat_counter #(.W(16)) u_repeat_cnt (
        .pclk   (pclk),
        .prst_n (prst_n),
        .i_clr  (!bus.enable),
        .i_inc  (w_repeat_evt),
        .o_cnt  (w_repeat_cnt)
    );

    vdma_sat_counter #(.W(16)) u_drop_cnt (
        .pclk   (pclk),
        .prst_n (prst_n),
        .i_clr  (!bus.enable),
        .i_inc  (w_drop_evt),
        .o_cnt  (w_drop_cnt)
    );

    // ---------------------------------------------------------------- outputs
    assign bus.rd_baseaddr  = bus.base_addr_cfg + r_rd_off;
    assign bus.wr_baseaddr  = bus.base_addr_cfg + r_wr_off;
    assign bus.wr_idx       = r_wr_idx;
    assign bus.rd_idx       = r_rd_idx;
    assign bus.latest_idx   = r_latest_idx;
    assign bus.latest_valid = r_latest_valid;
    assign bus.rd_repeat    = r_rd_repeat;
    assign bus.wr_drop      = r_wr_drop;
    assign bus.repeat_cnt   = w_repeat_cnt;
    assign bus.drop_cnt     = w_drop_cnt;
    assign bus.wr_state     = r_state;

    // The writer must never own the displayed buffer or the newest frame.
    a_wr_not_rd: assert property (@(posedge pclk) disable iff (!prst_n)
        (r_state == W_ACTIVE) |-> (r_wr_idx != r_rd_idx));
    a_wr_not_latest: assert property (@(posedge pclk) disable iff (!prst_n)
        ((r_state == W_ACTIVE) && r_latest_valid) |-> (r_wr_idx != r_latest_idx));

endmodule

// File: doc/vdma_frame_buf_scheduler.md
Name: vdma_frame_buf_scheduler

Overview:
Triple-buffer scheduler for the VDMA DDR frame store.
- Assigns the DDR frame-buffer base address to the write path (frame producer).
- Assigns the DDR frame-buffer base address to the read path (video32bit output block, via its video_baseaddr input).
- The reader always gets the newest completed frame. The writer never writes into the buffer being read or into the newest completed one.
- Single pclk domain; writer events arrive already synchronized to pclk.

Parameters:
ADDR_BITS, 25, DDR word-address width.
FRAME_STRIDE, 25'h0080000, address offset between consecutive buffers. Buffer n base = base_addr_cfg + n*FRAME_STRIDE, truncated to ADDR_BITS.

Ports:
pclk  in  1  clock
prst_n  in  1  reset, asynchronous, active-low
enable  in  1  scheduler enable; low = synchronous return to defaults
base_addr_cfg  in  ADDR_BITS  buffer 0 base address (static while enable=1)
wr_frame_start  in  1  pulse: writer begins a frame
wr_frame_done  in  1  pulse: writer completed a frame
wr_frame_abort  in  1  pulse: writer abandons the current frame
wr_baseaddr  out  ADDR_BITS  base address the writer must use
rd_vsync  in  1  reader vsync (same signal as the reader's invsync)
rd_baseaddr  out  ADDR_BITS  base address for the reader
wr_idx, rd_idx, latest_idx  out  2 each  buffer indices (0..2)
latest_valid  out  1  at least one completed frame exists
rd_repeat  out  1  pulse: reader re-shows the same frame
wr_drop  out  1  pulse: writer frame lost (start while active)
repeat_cnt, drop_cnt  out  16 each  saturating event counters

Behaviour:
Reset values (prst_n low, or enable low on a clock edge):
- rd_idx=0, latest_idx=0, wr_idx=1, latest_valid=0.
- Write FSM in W_IDLE.
- rd_repeat=0, wr_drop=0, repeat_cnt=0, drop_cnt=0.
- rd_baseaddr=wr_baseaddr=base_addr_cfg (async reset value = base_addr_cfg).

Write FSM, states W_IDLE and W_ACTIVE:
- W_IDLE + wr_frame_start: wr_idx <= free index (defined below); go to W_ACTIVE.
- W_ACTIVE + wr_frame_done: latest_idx <= wr_idx; latest_valid <= 1; go to W_IDLE.
- W_ACTIVE + wr_frame_abort: go to W_IDLE; latest unchanged.
- W_ACTIVE + wr_frame_start: wr_drop pulses 1 cycle; drop_cnt++; stay in W_ACTIVE; wr_idx kept.
- Priority when several arrive together: abort > done > start. Done and start in the same cycle: done is taken; the start is ignored and counted as a drop.
- done or abort in W_IDLE: ignored.

Free index:
- Lowest index in {0,1,2} that differs from rd_idx and, if latest_valid, from latest_idx.
- Always exists with 3 buffers.

Read side:
- rd_vsync is registered once; the rising edge is detected on the registered copy.
- At that edge, if latest_valid and latest_idx != rd_idx: rd_idx <= latest_idx.
- Otherwise rd_repeat pulses 1 cycle and repeat_cnt++.
- Decision uses the pre-update latest_idx. A wr_frame_done in the same cycle is not visible until the next vsync.

Outputs:
- rd_baseaddr and wr_baseaddr are registered from their index: base_addr_cfg + idx*FRAME_STRIDE.
- rd_baseaddr is valid 2 pclk after the rd_vsync rising edge (register stage + address stage).
- rd_baseaddr is held constant for the rest of the frame. The reader samples it during vsync high; vsync high must last ≥3 pclk.
- wr_baseaddr is valid 1 cycle after the W_ACTIVE entry and is held until the next start.

Invariant, checked by assertion:
- In W_ACTIVE, wr_idx != rd_idx.
- In W_ACTIVE, wr_idx != latest_idx when latest_valid.

Counters:
- 16-bit; saturate at 16'hFFFF with no wrap.
- Cleared only by reset or enable=0.

Enable:
- Deasserting enable mid-frame aborts the write silently (no wr_drop).
- Buffer ownership restarts from defaults.

Decomposition:
Shared package vdma_pkg:
- write-FSM state encoding (W_IDLE=1'b0, W_ACTIVE=1'b1);
- buffer index type (2 bits);
- constant NUM_FRAME_BUF=3.

One natural sub-module: vdma_sat_counter (16-bit saturating increment/clear), instantiated twice. Edge detect is inline.

Test Plan:
1. Reset, enable=1, base=0x0100000, stride 0x80000 -> rd_baseaddr=0x0100000, wr_baseaddr after first start = 0x0180000 (idx 1), latest_valid=0.
2. start, done, then rd_vsync rise -> rd_idx=1, rd_baseaddr=0x0180000 2 cycles after edge; next start picks idx 0; rd_repeat stays 0.
3. Two rd_vsync rises with no done between -> second rise gives rd_repeat 1-cycle pulse, repeat_cnt=1, rd_idx unchanged.
4. start, start (no done) -> wr_drop pulse, drop_cnt=1, wr_idx unchanged. Then abort -> W_IDLE, latest_idx unchanged.
5. wr_frame_done and rd_vsync rise in the same cycle -> rd_idx keeps the old value, rd_repeat=1; the following vsync adopts the new frame.
6. 70000 repeated vsyncs, then enable=0 mid-write -> repeat_cnt saturates at 0xFFFF. After enable=0, all indices and counters return to defaults, wr_drop not pulsed, invariant assertion never fires.
